// File: rtl/pmem_fetch.sv
// Instruction fetch front-end. Drives word addresses into a synchronous-address
// program memory, captures the returned word one cycle later, and buffers the
// words in a small shift FIFO. A valid/ready handshake hands them to decode.
// A redirect flushes the buffered words and the in-flight word.
//
// Handshake: the head entry (out_instr, out_instr_pc) is offered whenever
// out_instr_valid is high. It is consumed on a rising edge where both
// out_instr_valid and in_instr_ready are high. While valid is high and ready is
// low, the head holds its value.
module pmem_fetch #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int RESET_PC   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] out_pmem_addr,
  input  logic [WORD_WIDTH-1:0] in_pmem_word,
  input  logic                  in_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] in_redirect_addr,
  output logic                  out_instr_valid,
  output logic [WORD_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_instr_pc,
  input  logic                  in_instr_ready
);

  localparam int INC = WORD_WIDTH / 8;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int IW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] INC_A      = ADDR_WIDTH'(INC);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(INC - 1));
  localparam logic [ADDR_WIDTH-1:0] RESET_A    = ADDR_WIDTH'(RESET_PC);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic [CW-1:0]         count;
  logic [WORD_WIDTH-1:0] fifo_word [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [CW:0]           occupancy;
  logic [CW-1:0]         wr_idx_full;
  logic [IW-1:0]         wr_idx;

  // Memory address is combinational so a redirect target is issued in the
  // same cycle the redirect is seen.
  assign out_pmem_addr = in_redirect_valid ? (in_redirect_addr & ALIGN_MASK) : fetch_pc;

  assign out_instr_valid = (count != '0);
  assign out_instr       = fifo_word[0];
  assign out_instr_pc    = fifo_pc[0];

  // Issue control. Counting the in-flight word as already occupying a slot
  // guarantees a captured word always has room in the FIFO.
  always_comb begin
    pop         = out_instr_valid & in_instr_ready;
    push        = inflight & ~in_redirect_valid;
    occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    issue       = in_redirect_valid | (occupancy < (CW + 1)'(FIFO_DEPTH));
    wr_idx_full = pop ? (count - CW'(1)) : count;
    wr_idx      = wr_idx_full[IW-1:0];
  end

  // Fetch pointer and in-flight tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_A;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (issue) begin
      fetch_pc    <= out_pmem_addr + INC_A;
      inflight    <= 1'b1;
      inflight_pc <= out_pmem_addr;
    end else begin
      inflight    <= 1'b0;
    end
  end

  // Shift FIFO: entry 0 is always the head, so the outputs come straight from
  // registers. A pop shifts everything down; a push lands just past the last
  // valid entry after that shift.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_word[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (in_redirect_valid) begin
      count <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
          fifo_word[i] <= fifo_word[i+1];
          fifo_pc[i]   <= fifo_pc[i+1];
        end
      end
      if (push) begin
        fifo_word[wr_idx] <= in_pmem_word;
        fifo_pc[wr_idx]   <= inflight_pc;
      end
      count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_pmem_fetch.sv
// Testbench for pmem_fetch. A memory model returns word(addr) = addr ^ 16'hA5A5
// one cycle after the address. The reference model tracks the next PC decode
// should see and how many cycles have passed since the last restart (reset
// release or redirect); the head must be valid from the second cycle after a
// restart onward and must carry the expected PC and word.
module tb_pmem_fetch;

  localparam int WW = 16;
  localparam int AW = 12;
  localparam int RESET_PC = 0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] out_pmem_addr;
  logic [WW-1:0] in_pmem_word = '0;
  logic          in_redirect_valid = 1'b0;
  logic [AW-1:0] in_redirect_addr = '0;
  logic          out_instr_valid;
  logic [WW-1:0] out_instr;
  logic [AW-1:0] out_instr_pc;
  logic          in_instr_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [AW-1:0] exp_pc;
  int            age;
  logic [AW-1:0] exp_q[$];

  pmem_fetch #(
    .WORD_WIDTH(WW),
    .ADDR_WIDTH(AW),
    .RESET_PC(RESET_PC),
    .FIFO_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .out_pmem_addr(out_pmem_addr),
    .in_pmem_word(in_pmem_word),
    .in_redirect_valid(in_redirect_valid),
    .in_redirect_addr(in_redirect_addr),
    .out_instr_valid(out_instr_valid),
    .out_instr(out_instr),
    .out_instr_pc(out_instr_pc),
    .in_instr_ready(in_instr_ready)
  );

  // Clock and reset-free clock generator.
  always #5 clock = ~clock;

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    return WW'({4'b0, a}) ^ 16'hA5A5;
  endfunction

  // Synchronous-address program memory model.
  always @(posedge clock) in_pmem_word <= mem_word(out_pmem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hold reset for two cycles, check reset values, release at a falling edge.
  task automatic do_reset();
    reset             = 1'b1;
    in_redirect_valid = 1'b0;
    in_instr_ready    = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_valid", 32'(out_instr_valid), 32'd0);
    check("rst_instr", 32'(out_instr), 32'd0);
    check("rst_pc", 32'(out_instr_pc), 32'd0);
    check("rst_addr", 32'(out_pmem_addr), 32'(RESET_PC));
    reset  = 1'b0;
    age    = 0;
    exp_pc = AW'(RESET_PC);
  endtask

  // One cycle: drive inputs, check the head against the model, advance model.
  task automatic cycle(input logic rdy, input logic rv, input logic [AW-1:0] raddr);
    in_instr_ready    = rdy;
    in_redirect_valid = rv;
    in_redirect_addr  = raddr;
    #1;
    check("valid", 32'(out_instr_valid), 32'(age >= 2));
    if (age >= 2) begin
      check("pc", 32'(out_instr_pc), 32'(exp_pc));
      check("word", 32'(out_instr), 32'(mem_word(exp_pc)));
      if (rdy) begin
        exp_q.push_back(exp_pc);
        exp_pc = exp_pc + AW'(2);
      end
    end
    if (rv) begin
      exp_pc = raddr & ~AW'(1);
      age = 1;
    end else begin
      age++;
    end
    @(negedge clock);
    in_redirect_valid = 1'b0;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(rdy, 1'b0, '0);
  endtask

  initial begin
    // Streaming from reset with ready held high.
    do_reset();
    run(14, 1'b1);
    check("stream_count", 32'(exp_q.size()), 32'd12);
    exp_q.delete();

    // Back-pressure: FIFO fills and fetch stalls at 8.
    do_reset();
    run(2, 1'b1);
    run(10, 1'b0);
    #1;
    check("stall_addr", 32'(out_pmem_addr), 32'h8);
    run(10, 1'b1);

    // Redirect while FIFO holds 4,6 and 8 is in flight.
    do_reset();
    run(4, 1'b1);
    run(1, 1'b0);
    cycle(1'b0, 1'b1, 12'h100);
    run(8, 1'b1);

    // Unaligned redirect, then a second redirect on the next cycle.
    cycle(1'b1, 1'b1, 12'h105);
    cycle(1'b1, 1'b1, 12'h200);
    run(6, 1'b1);
    cycle(1'b1, 1'b1, 12'h105);
    run(4, 1'b1);

    // Wrap from the top of the address space.
    cycle(1'b1, 1'b1, 12'hFFC);
    run(6, 1'b1);

    // Randomized ready and redirects.
    for (int i = 0; i < 400; i++) begin
      logic          r;
      logic          rv;
      logic [AW-1:0] ra;
      r  = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 19) == 0);
      ra = AW'($urandom_range(0, 4095));
      cycle(r, rv, ra);
    end

    // Asynchronous reset mid-stream with the FIFO full.
    run(12, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", 32'(out_instr_valid), 32'd0);
    check("async_instr", 32'(out_instr), 32'd0);
    check("async_addr", 32'(out_pmem_addr), 32'(RESET_PC));
    @(negedge clock);
    reset  = 1'b0;
    age    = 0;
    exp_pc = AW'(RESET_PC);
    run(10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
